// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions package (cpu_defs): reset vector, IF->ID bundle layout
// and the opcodes the fetch stage recognises for static prediction.
package cpu_defs;

    localparam logic [31:0] RESET_PC   = 32'h1C00_0000;
    localparam int          IF_TO_ID_W = 65;

    localparam logic [5:0]  OP_B  = 6'h14;
    localparam logic [5:0]  OP_BL = 6'h15;

    localparam int ZIP_PREDICT_BIT = 64;
    localparam int ZIP_INST_HI     = 63;
    localparam int ZIP_INST_LO     = 32;
    localparam int ZIP_PC_HI       = 31;
    localparam int ZIP_PC_LO       = 0;

    // Packed in the same order as the field offsets above.
    typedef struct packed {
        logic        predict;
        logic [31:0] inst;
        logic [31:0] pc;
    } if_to_id_t;

    function automatic logic is_static_taken(input logic [5:0] opcode);
        return (opcode == OP_B) || (opcode == OP_BL);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bundle of the instruction-SRAM bus and the IF->ID handshake; the fetch stage
// is the master, memory plus decode stage together form the slave side.
interface if_fetch_stage_if;
    import cpu_defs::*;

    logic                  inst_sram_en;
    logic [3:0]            inst_sram_we;
    logic [31:0]           inst_sram_addr;
    logic [31:0]           inst_sram_wdata;
    logic [31:0]           inst_sram_rdata;

    logic                  ID_allowin;
    logic                  flush;
    logic [31:0]           pc_real;
    logic                  IF_valid;
    logic [IF_TO_ID_W-1:0] IF_to_ID_zip;

    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        input  ID_allowin, flush, pc_real,
        output IF_valid, IF_to_ID_zip
    );

    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        output ID_allowin, flush, pc_real,
        input  IF_valid, IF_to_ID_zip
    );

endinterface

// File: rtl/if_fetch_stage_predictor.sv
// Static predictor: B and BL are always taken; the target is the PC plus the
// sign-extended 26-bit word offset, which is split across two instruction fields.
module if_static_predictor
    import cpu_defs::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        taken_o,
    output logic [31:0] target_o
);

    logic [25:0] i26;

    always_comb begin
        i26      = {inst_i[9:0], inst_i[25:10]};
        taken_o  = is_static_taken(inst_i[31:26]);
        target_o = pc_i + {{4{i26[25]}}, i26, 2'b00};
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: next-PC generation, 1-cycle-latency SRAM fetch,
// stall buffering of the returned word, and flush redirection from ID.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
    input logic               clk,
    input logic               rst,
    if_fetch_stage_if.master  bus
);
    import cpu_defs::if_to_id_t;

    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        req_q, req_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    logic [31:0] if_inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        predict;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fetch;
    if_to_id_t   zip;

    if_static_predictor u_predictor (
        .inst_i   (if_inst),
        .pc_i     (if_pc_q),
        .taken_o  (pred_taken),
        .target_o (pred_target)
    );

    always_comb begin
        // The SRAM only holds its data for one cycle; after that the buffer owns it.
        if_inst = buf_valid_q ? inst_buf_q : bus.inst_sram_rdata;
        predict = if_valid_q & pred_taken;
        seq_pc  = predict ? pred_target : if_pc_q + 32'd4;
        nextpc  = bus.flush ? bus.pc_real : seq_pc;
        fetch   = ~rst & (~if_valid_q | bus.ID_allowin | bus.flush);
    end

    always_comb begin
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        req_d       = 1'b0;
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        if (fetch) begin
            if_pc_d     = nextpc;
            if_valid_d  = 1'b1;
            req_d       = 1'b1;
            buf_valid_d = 1'b0;
        end else if (req_q && !buf_valid_q) begin
            // First stall cycle after a request: rdata is still the fetched word.
            inst_buf_d  = bus.inst_sram_rdata;
            buf_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the next-state logic above stays purely combinational.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q  <= 1'b0;
            if_pc_q     <= RESET_PC - 32'd4;
            req_q       <= 1'b0;
            buf_valid_q <= 1'b0;
            inst_buf_q  <= '0;
        end else begin
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            req_q       <= req_d;
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    always_comb begin
        zip.predict = predict;
        zip.inst    = if_inst;
        zip.pc      = if_pc_q;

        bus.inst_sram_en    = fetch;
        bus.inst_sram_we    = 4'b0000;
        bus.inst_sram_addr  = nextpc;
        bus.inst_sram_wdata = 32'h0;
        bus.IF_valid        = ~rst & if_valid_q & ~bus.flush;
        bus.IF_to_ID_zip    = rst ? '0 : zip;
    end

endmodule
